// File: rtl/sorter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sorter_rr_scheduler
// Description : Round-robin scheduler that shares one sorter control unit
//               between NREQ symbol-stream requesters. The winner's burst
//               drives sorter start/M for len*CYC(M) cycles, then the block
//               waits for sorter done (with timeout) and acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module sorter_rr_scheduler #(
    parameter int NREQ       = 4,
    parameter int LEN_W      = 8,
    parameter int CYC_QPSK   = 1,
    parameter int CYC_QAM16  = 5,
    parameter int CYC_QAM64  = 1,
    parameter int CYC_QAM256 = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       req_m,
    input  logic [LEN_W*NREQ-1:0]   req_len,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic                    busy,
    output logic                    sorter_start,
    output logic [1:0]              sorter_M,
    input  logic                    sorter_done
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = LEN_W + 3;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [NREQ-1:0]     grant_nx, ack_nx;
    logic                err_nx, start_nx;
    logic [1:0]          m_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [TO_W-1:0]     to_cnt, to_nx;
    logic [IDX_W-1:0]    owner, owner_nx;
    logic [IDX_W-1:0]    rr_ptr, ptr_nx;

    logic                any_req;
    logic [IDX_W-1:0]    winner, pick;
    logic [1:0]          win_m;
    logic [LEN_W-1:0]    win_len, len_eff;
    logic [CNT_W-1:0]    cyc, hold;

    // Index that is 'step' places after base, wrapping at NREQ.
    function automatic logic [IDX_W-1:0] wrap_next(input logic [IDX_W-1:0] base,
                                                   input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDX_W'(sum);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first active request after the last owner.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        pick    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pick = wrap_next(rr_ptr, k);
            if (!any_req && req[pick]) begin
                any_req = 1'b1;
                winner  = pick;
            end
        end
    end

    // Burst length of the winner: len (min 1) times cycles-per-block of its modulation.
    always_comb begin
        win_m   = req_m[2*int'(winner) +: 2];
        win_len = req_len[LEN_W*int'(winner) +: LEN_W];
        len_eff = (win_len == '0) ? LEN_W'(1) : win_len;
        case (win_m)
            2'b00:   cyc = CNT_W'(CYC_QPSK);
            2'b01:   cyc = CNT_W'(CYC_QAM16);
            2'b10:   cyc = CNT_W'(CYC_QAM64);
            default: cyc = CNT_W'(CYC_QAM256);
        endcase
        hold = CNT_W'(len_eff) * cyc;
    end

    // Next-state and next-output decode; ack/err default low so they pulse one cycle.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        ack_nx   = '0;
        err_nx   = 1'b0;
        start_nx = sorter_start;
        m_nx     = sorter_M;
        cnt_nx   = cnt;
        to_nx    = to_cnt;
        owner_nx = owner;
        ptr_nx   = rr_ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = RUN;
                    grant_nx = onehot(winner);
                    start_nx = 1'b1;
                    m_nx     = win_m;
                    cnt_nx   = hold;
                    owner_nx = winner;
                end
            end
            RUN: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nx = WAIT_DONE;
                    start_nx = 1'b0;
                    to_nx    = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (sorter_done) begin
                    state_nx = RELEASE;
                    ack_nx   = grant;
                end else if (to_cnt >= TO_LAST) begin
                    // This edge closes the TIMEOUT-th cycle spent waiting.
                    state_nx = RELEASE;
                    err_nx   = 1'b1;
                end else if (to_cnt != TO_MAX) begin
                    to_nx = to_cnt + TO_W'(1);
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                grant_nx = '0;
                ptr_nx   = owner;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset clears everything without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= '0;
            ack          <= '0;
            err          <= 1'b0;
            sorter_start <= 1'b0;
            sorter_M     <= 2'b00;
            cnt          <= '0;
            to_cnt       <= '0;
            owner        <= '0;
            rr_ptr       <= IDX_W'(NREQ - 1);
        end else begin
            state        <= state_nx;
            grant        <= grant_nx;
            ack          <= ack_nx;
            err          <= err_nx;
            sorter_start <= start_nx;
            sorter_M     <= m_nx;
            cnt          <= cnt_nx;
            to_cnt       <= to_nx;
            owner        <= owner_nx;
            rr_ptr       <= ptr_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/sorter_rr_scheduler.md
Name: sorter_rr_scheduler

Overview:
- Shares one sorter control unit between NREQ symbol-stream requesters in the V2V transmit path.
- Each requester asks for a burst of symbol blocks in one modulation (QPSK/QAM16/QAM64/QAM256).
- Grants are round-robin. The block drives the sorter's start/M pair for the computed burst duration, waits for the sorter's done, then acknowledges the requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LEN_W, 8, width of each requester's block-count field
- CYC_QPSK, 1, start-high cycles per block in QPSK
- CYC_QAM16, 5, start-high cycles per block in QAM16
- CYC_QAM64, 1, start-high cycles per block in QAM64
- CYC_QAM256, 1, start-high cycles per block in QAM256
- TIMEOUT, 255, max WAIT_DONE cycles before abort

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_m  in  2*NREQ  modulation per requester, slice i = [2i+1:2i]; 00 QPSK, 01 QAM16, 10 QAM64, 11 QAM256
- req_len  in  LEN_W*NREQ  blocks per burst, slice i
- grant  out  NREQ  one-hot owner, registered
- ack  out  NREQ  one-cycle completion pulse to owner
- err  out  1  one-cycle timeout pulse
- busy  out  1  high in any state except IDLE
- sorter_start  out  1  drives sorter start
- sorter_M  out  2  drives sorter M
- sorter_done  in  1  sorter done level

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; grant=0, ack=0, err=0, busy=0, sorter_start=0, sorter_M=00. rr_ptr=NREQ-1, so requester 0 has first priority.
- States: IDLE, RUN, WAIT_DONE, RELEASE.
- IDLE:
  - If req!=0, pick the first set bit searching from rr_ptr+1 upward, with wrap.
  - At the next edge: grant=onehot(winner), sorter_start=1, sorter_M=req_m[winner]. Latch hold=len_eff*CYC(M); load the counter.
  - len_eff = req_len[winner], or 1 if that field is 0.
  - Go to RUN.
  - Latency: req seen in IDLE at edge t gives grant and sorter_start high from edge t+1.
- Arithmetic: counter width LEN_W+3; the product is computed at full width with no truncation. M and len are latched once at grant; later changes on req_m/req_len are ignored.
- RUN:
  - sorter_start=1 for exactly hold cycles; the counter decrements each cycle.
  - When the counter is at 1, the next edge sets sorter_start=0 and enters WAIT_DONE with the timeout counter cleared.
  - Deassertion of the owner's req during RUN is ignored; the burst completes.
- WAIT_DONE:
  - sorter_start=0.
  - If sorter_done is sampled 1: go to RELEASE; ack[owner]=1 for that cycle.
  - Else, when the timeout count reaches TIMEOUT: go to RELEASE with err=1 and ack=0.
  - The timeout counter saturates; it does not wrap.
- RELEASE:
  - Lasts one cycle. grant is still held, sorter_start=0.
  - rr_ptr=owner, updated on both success and timeout.
  - Next state IDLE, with grant=0.
  - Guarantees at least 2 start-low cycles between bursts, so the sorter returns to its idle state.
- Simultaneous requests: exactly one grant; the others wait.
- A requester that is still requesting after its ack is served again only after every other pending requester has been served.
- Invariants: grant is always one-hot or zero. sorter_start=1 only while grant!=0. ack and err are never both high.
- Reset mid-burst: outputs drop to reset values immediately (asynchronously); no ack or err is produced.

Test Plan:
- Single QAM16, len=3 on req[2] from reset → grant=0100 one cycle after req; sorter_start high exactly 15 cycles, M=01; sorter_done pulsed 2 cycles later → ack[2] one cycle, then grant=0, busy=0.
- req=1111 all QPSK, len=1, done returned 1 cycle after start falls → grant order 0,1,2,3,0 with ack pulses in the same order; start-low gap ≥2 cycles between bursts.
- req_len=0 on QAM256 → sorter_start high exactly 1 cycle.
- QAM16, len=255 → sorter_start high 1275 cycles, with no counter overflow.
- sorter_done held 0 → err pulses exactly TIMEOUT cycles after WAIT_DONE entry; ack stays 0; the next requester is granted afterward.
- rst low midway through RUN (start high) → grant, sorter_start and busy go to 0 without waiting for a clock edge; after release, the first grant goes to requester 0 when req=1111.
